// File: rtl/pipa_moding_sequencer.sv
// PIPA pulse scheduler: per-axis 3-3 / 4-2 / 2-4 frame moding locked to the AGC PIPASW/PIPDAT strobes.
// Optional build macro PIPA_FAIL_INJECT_EN adds fail_inj / fail_seen for PIPA-fail exercising.
module pipa_moding_sequencer #(
    parameter int RATE_W = 12,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              PIPASW,
    input  logic              PIPDAT,
    input  logic              run,
    input  logic [RATE_W-1:0] rate_x,
    input  logic [RATE_W-1:0] rate_y,
    input  logic [RATE_W-1:0] rate_z,
    input  logic              cnt_clr,
`ifdef PIPA_FAIL_INJECT_EN
    input  logic [2:0]        fail_inj,
    output logic [2:0]        fail_seen,
`endif
    output logic              PIPAXp,
    output logic              PIPAXm,
    output logic              PIPAYp,
    output logic              PIPAYm,
    output logic              PIPAZp,
    output logic              PIPAZm,
    output logic [2:0]        slot,
    output logic              frame_stb,
    output logic [CNT_W-1:0]  net_x,
    output logic [CNT_W-1:0]  net_y,
    output logic [CNT_W-1:0]  net_z,
    output logic [2:0]        ovr
);

    // Per-axis frame mode (one small state machine per axis, advanced on the slot wrap):
    // state   | meaning
    // MODE_33 | 3 plus slots then 3 minus slots, zero net
    // MODE_42 | 4 plus slots then 2 minus slots, net +2
    // MODE_24 | 2 plus slots then 4 minus slots, net -2
    typedef enum logic [1:0] {
        MODE_33 = 2'd0,
        MODE_42 = 2'd1,
        MODE_24 = 2'd2
    } mode_e;

    localparam int ACC_W     = RATE_W + 2;
    localparam int ACC_LIM_I = 2 * THRESH - 1;
    localparam logic signed [ACC_W-1:0] THR_S   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(ACC_LIM_I);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic [2:0]              LAST_SLOT = 3'd5;

    logic                    pipasw_q, pipasw_d;
    logic                    pipdat_q, pipdat_d;
    logic [2:0]              slot_q, slot_d;
    logic                    frame_stb_q, frame_stb_d;
    mode_e                   mode_q [3];
    mode_e                   mode_d [3];
    logic signed [ACC_W-1:0] acc_q [3];
    logic signed [ACC_W-1:0] acc_d [3];
    logic [CNT_W-1:0]        net_q [3];
    logic [CNT_W-1:0]        net_d [3];
    logic [2:0]              ovr_q, ovr_d;

    logic                    sw_rise, dat_rise, wrap;
    logic [RATE_W-1:0]       rate_a [3];
    logic signed [ACC_W-1:0] sum_a [3];
    logic signed [ACC_W-1:0] adj_a [3];
    logic [2:0]              plus_a [3];
    logic [2:0]              ap, am, fail_a;

    assign rate_a[0] = rate_x;
    assign rate_a[1] = rate_y;
    assign rate_a[2] = rate_z;

`ifdef PIPA_FAIL_INJECT_EN
    logic [2:0] fail_seen_q, fail_seen_d;

    assign fail_a = fail_inj;

    always_comb begin
        fail_seen_d = fail_seen_q | (fail_inj & {3{PIPDAT}});
        if (cnt_clr) begin
            fail_seen_d = 3'b000;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            fail_seen_q <= 3'b000;
        end else begin
            fail_seen_q <= fail_seen_d;
        end
    end

    assign fail_seen = fail_seen_q;
`else
    assign fail_a = 3'b000;
`endif

    // Pulse decode: registered slot/mode, live PIPDAT gate.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            plus_a[i] = 3'd3;
            case (mode_q[i])
                MODE_42: plus_a[i] = 3'd4;
                MODE_24: plus_a[i] = 3'd2;
                default: plus_a[i] = 3'd3;
            endcase
            ap[i] = PIPDAT & ((slot_q <  plus_a[i]) | fail_a[i]);
            am[i] = PIPDAT & ((slot_q >= plus_a[i]) | fail_a[i]);
        end
    end

    always_comb begin
        pipasw_d    = PIPASW;
        pipdat_d    = PIPDAT;
        sw_rise     = PIPASW & ~pipasw_q;
        dat_rise    = PIPDAT & ~pipdat_q;
        wrap        = sw_rise & (slot_q == LAST_SLOT);
        frame_stb_d = wrap;
        slot_d      = slot_q;
        if (sw_rise) begin
            slot_d = wrap ? 3'd0 : slot_q + 3'd1;
        end
        ovr_d = ovr_q;

        for (int i = 0; i < 3; i++) begin
            mode_d[i] = mode_q[i];
            acc_d[i]  = acc_q[i];
            net_d[i]  = net_q[i];
            sum_a[i]  = acc_q[i] + ACC_W'(signed'(rate_a[i]));
            adj_a[i]  = sum_a[i];

            if (wrap && run) begin
                mode_d[i] = MODE_33;
                if (sum_a[i] >= THR_S) begin
                    mode_d[i] = MODE_42;
                    adj_a[i]  = sum_a[i] - THR_S;
                end else if (sum_a[i] <= -THR_S) begin
                    mode_d[i] = MODE_24;
                    adj_a[i]  = sum_a[i] + THR_S;
                end
                if (adj_a[i] > ACC_MAX) begin
                    acc_d[i] = ACC_MAX;
                    ovr_d[i] = 1'b1;
                end else if (adj_a[i] < ACC_MIN) begin
                    acc_d[i] = ACC_MIN;
                    ovr_d[i] = 1'b1;
                end else begin
                    acc_d[i] = adj_a[i];
                end
            end else if (wrap) begin
                mode_d[i] = MODE_33;
            end

            // Counting uses this cycle's decode, i.e. the pre-increment slot.
            if (cnt_clr) begin
                net_d[i] = '0;
            end else if (dat_rise && !fail_a[i]) begin
                if (ap[i]) begin
                    net_d[i] = net_q[i] + CNT_W'(1);
                end else if (am[i]) begin
                    net_d[i] = net_q[i] - CNT_W'(1);
                end
            end
        end

        if (cnt_clr) begin
            ovr_d = 3'b000;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            pipasw_q    <= 1'b0;
            pipdat_q    <= 1'b0;
            slot_q      <= 3'd0;
            frame_stb_q <= 1'b0;
            ovr_q       <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= MODE_33;
                acc_q[i]  <= '0;
                net_q[i]  <= '0;
            end
        end else begin
            pipasw_q    <= pipasw_d;
            pipdat_q    <= pipdat_d;
            slot_q      <= slot_d;
            frame_stb_q <= frame_stb_d;
            ovr_q       <= ovr_d;
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= mode_d[i];
                acc_q[i]  <= acc_d[i];
                net_q[i]  <= net_d[i];
            end
        end
    end

    assign PIPAXp    = ap[0];
    assign PIPAXm    = am[0];
    assign PIPAYp    = ap[1];
    assign PIPAYm    = am[1];
    assign PIPAZp    = ap[2];
    assign PIPAZm    = am[2];
    assign slot      = slot_q;
    assign frame_stb = frame_stb_q;
    assign net_x     = net_q[0];
    assign net_y     = net_q[1];
    assign net_z     = net_q[2];
    assign ovr       = ovr_q;

endmodule
